// File: rtl/rfile_pkg.sv
// Shared types and the write-port hit search used by both the read bypass
// and the scoreboard busy-clear path.
package rfile_pkg;

    localparam int DefDataWidth = 32;
    localparam int DefNumRegs   = 32;
    localparam int DefAddrWidth = $clog2(DefNumRegs);

    // Upper bounds used to give write_hit fixed-width arguments; callers
    // zero-extend their narrower vectors up to these widths.
    localparam int MaxWrite     = 4;
    localparam int MaxAddrWidth = 8;
    localparam int PortIdxWidth = $clog2(MaxWrite);

    typedef logic [DefAddrWidth-1:0] reg_addr_t;
    typedef logic [DefDataWidth-1:0] reg_data_t;

    typedef logic [MaxAddrWidth-1:0]                 hit_addr_t;
    typedef logic [MaxWrite-1:0][MaxAddrWidth-1:0]   wr_addr_vec_t;

    typedef struct packed {
        logic                    hit;
        logic [PortIdxWidth-1:0] port;
    } hit_t;

    // Reports whether any enabled write port targets addr; the highest-index
    // matching port is returned so that later ports take priority.
    function automatic hit_t write_hit(input hit_addr_t          addr,
                                       input logic [MaxWrite-1:0] wr_en,
                                       input wr_addr_vec_t       wr_addr);
        hit_t h;
        h.hit  = 1'b0;
        h.port = '0;
        for (int k = 0; k < MaxWrite; k++) begin
            if (wr_en[k] && (wr_addr[k] == addr)) begin
                h.hit  = 1'b1;
                h.port = k[PortIdxWidth-1:0];
            end
        end
        return h;
    endfunction

endpackage

// File: rtl/rfile_scoreboard.sv
// Per-register busy bits tracking issued-but-not-written-back destinations.
module rfile_scoreboard
    import rfile_pkg::*;
#(
    parameter int NumRegs   = DefNumRegs,
    parameter int AddrWidth = $clog2(NumRegs),
    parameter int NumRead   = 2
) (
    input  logic                              Clk,
    input  logic                              reset,
    input  logic                              iss_en,
    input  logic [AddrWidth-1:0]              iss_addr,
    input  logic [MaxWrite-1:0]               wr_en_ext,
    input  wr_addr_vec_t                      wr_addr_ext,
    input  logic [NumRead-1:0][AddrWidth-1:0] rd_addr,
    input  logic [NumRead-1:0]                rd_bypass,
    output logic [NumRead-1:0]                rd_busy,
    output logic                              any_busy
);

    logic [NumRegs-1:0] busy;
    logic [NumRegs-1:0] clr;

    // Per-register clear: any enabled write to the register this cycle.
    always_comb begin
        clr = '0;
        for (int r = 0; r < NumRegs; r++) begin
            clr[r] = write_hit(MaxAddrWidth'(r), wr_en_ext, wr_addr_ext).hit;
        end
    end

    // Busy update; an issue beats a writeback to the same register because
    // the new pending write supersedes the one being retired. x0 never sets.
    always_ff @(posedge Clk) begin
        if (reset) begin
            busy <= '0;
        end else begin
            for (int r = 0; r < NumRegs; r++) begin
                if (iss_en && (iss_addr == AddrWidth'(r)) && (r != 0)) begin
                    busy[r] <= 1'b1;
                end else if (clr[r]) begin
                    busy[r] <= 1'b0;
                end
            end
        end
    end

    // Bypassed reads are never reported busy; same-cycle issues are not seen.
    always_comb begin
        rd_busy = '0;
        for (int p = 0; p < NumRead; p++) begin
            rd_busy[p] = busy[rd_addr[p]] & ~rd_bypass[p];
        end
        any_busy = |busy;
    end

endmodule

// File: rtl/rfile_mp.sv
// Multi-port integer register file with write-first bypass, hardwired x0
// and a busy scoreboard for RAW hazard detection at issue.
module rfile_mp
    import rfile_pkg::*;
#(
    parameter int DataWidth = DefDataWidth,
    parameter int NumRegs   = DefNumRegs,
    parameter int AddrWidth = $clog2(NumRegs),
    parameter int NumRead   = 2,
    parameter int NumWrite  = 1
) (
    input  logic                               Clk,
    input  logic                               reset,
    input  logic [NumRead-1:0][AddrWidth-1:0]  rd_addr,
    output logic [NumRead-1:0][DataWidth-1:0]  rd_data,
    output logic [NumRead-1:0]                 rd_busy,
    input  logic [NumWrite-1:0]                wr_en,
    input  logic [NumWrite-1:0][AddrWidth-1:0] wr_addr,
    input  logic [NumWrite-1:0][DataWidth-1:0] wr_data,
    input  logic                               iss_en,
    input  logic [AddrWidth-1:0]               iss_addr,
    output logic                               any_busy
);

    logic [DataWidth-1:0] regs [NumRegs];

    logic [MaxWrite-1:0]  wr_en_ext;
    wr_addr_vec_t         wr_addr_ext;
    logic [DataWidth-1:0] wr_data_ext [MaxWrite];

    hit_t                 rd_hit [NumRead];
    logic [NumRead-1:0]   rd_bypass;

    // Widen the write ports to the fixed shape expected by write_hit;
    // unused slots are disabled and carry zero data.
    always_comb begin
        wr_en_ext   = '0;
        wr_addr_ext = '0;
        for (int k = 0; k < MaxWrite; k++) begin
            wr_data_ext[k] = '0;
        end
        for (int k = 0; k < NumWrite; k++) begin
            wr_en_ext[k]   = wr_en[k];
            wr_addr_ext[k] = MaxAddrWidth'(wr_addr[k]);
            wr_data_ext[k] = wr_data[k];
        end
    end

    // Storage: later ports overwrite earlier ones on the same edge, so the
    // highest-index port wins a conflict. x0 is never written.
    always_ff @(posedge Clk) begin
        if (reset) begin
            for (int r = 0; r < NumRegs; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int k = 0; k < NumWrite; k++) begin
                if (wr_en[k] && (wr_addr[k] != '0)) begin
                    regs[wr_addr[k]] <= wr_data[k];
                end
            end
        end
    end

    // Read ports: x0 reads zero, then same-cycle write bypass, then storage.
    always_comb begin
        rd_data   = '0;
        rd_bypass = '0;
        for (int p = 0; p < NumRead; p++) begin
            rd_hit[p]    = write_hit(MaxAddrWidth'(rd_addr[p]), wr_en_ext, wr_addr_ext);
            rd_bypass[p] = rd_hit[p].hit;
            if (rd_addr[p] == '0) begin
                rd_data[p] = '0;
            end else if (rd_hit[p].hit) begin
                rd_data[p] = wr_data_ext[rd_hit[p].port];
            end else begin
                rd_data[p] = regs[rd_addr[p]];
            end
        end
    end

    rfile_scoreboard #(
        .NumRegs   (NumRegs),
        .AddrWidth (AddrWidth),
        .NumRead   (NumRead)
    ) u_scoreboard (
        .Clk         (Clk),
        .reset       (reset),
        .iss_en      (iss_en),
        .iss_addr    (iss_addr),
        .wr_en_ext   (wr_en_ext),
        .wr_addr_ext (wr_addr_ext),
        .rd_addr     (rd_addr),
        .rd_bypass   (rd_bypass),
        .rd_busy     (rd_busy),
        .any_busy    (any_busy)
    );

endmodule

// File: tb/tb_rfile_mp.sv
// Bench for rfile_mp (2 read, 2 write ports): driver pushes expected read
// results from an array model; a negedge monitor pops and compares.
module tb_rfile_mp;

    localparam int NR = 2;
    localparam int NW = 2;

    logic                 Clk;
    logic                 reset;
    logic [NR-1:0][4:0]   rd_addr;
    logic [NR-1:0][31:0]  rd_data;
    logic [NR-1:0]        rd_busy;
    logic [NW-1:0]        wr_en;
    logic [NW-1:0][4:0]   wr_addr;
    logic [NW-1:0][31:0]  wr_data;
    logic                 iss_en;
    logic [4:0]           iss_addr;
    logic                 any_busy;

    rfile_mp #(
        .DataWidth (32),
        .NumRegs   (32),
        .NumRead   (NR),
        .NumWrite  (NW)
    ) dut (
        .Clk      (Clk),
        .reset    (reset),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .any_busy (any_busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        int          cyc;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  b;
        logic        ab;
    } exp_t;

    exp_t        q[$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;

    logic [31:0] mem [32];
    bit   [31:0] busy_m;

    // Reference model: architectural register array plus a busy bit per index.
    function automatic bit written(input logic [4:0] a);
        bit w = 1'b0;
        for (int k = 0; k < NW; k++) if (wr_en[k] && wr_addr[k] == a) w = 1'b1;
        return w;
    endfunction

    function automatic logic [31:0] exp_data(input logic [4:0] a);
        logic [31:0] v;
        if (a == 5'd0) return 32'd0;
        v = mem[a];
        for (int k = 0; k < NW; k++) if (wr_en[k] && wr_addr[k] == a) v = wr_data[k];
        return v;
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        return busy_m[a] && !written(a);
    endfunction

    task automatic model_edge();
        if (reset) begin
            for (int r = 0; r < 32; r++) mem[r] = 32'd0;
            busy_m = '0;
        end else begin
            for (int k = 0; k < NW; k++)
                if (wr_en[k] && wr_addr[k] != 5'd0) mem[wr_addr[k]] = wr_data[k];
            for (int k = 0; k < NW; k++)
                if (wr_en[k]) busy_m[wr_addr[k]] = 1'b0;
            if (iss_en && iss_addr != 5'd0) busy_m[iss_addr] = 1'b1;
        end
    endtask

    // One clock: optionally queue the expected outputs for the current
    // inputs, then advance the model on the edge.
    task automatic step(input bit chk);
        exp_t e;
        if (chk) begin
            e.cyc = cyc;
            e.d0  = exp_data(rd_addr[0]);
            e.d1  = exp_data(rd_addr[1]);
            e.b   = {exp_busy(rd_addr[1]), exp_busy(rd_addr[0])};
            e.ab  = |busy_m;
            q.push_back(e);
        end
        @(posedge Clk);
        model_edge();
        cyc++;
        #1;
    endtask

    task automatic idle();
        reset  = 1'b0;
        wr_en  = '0;
        iss_en = 1'b0;
    endtask

    task automatic rd2(input logic [4:0] a0, input logic [4:0] a1);
        rd_addr[0] = a0;
        rd_addr[1] = a1;
    endtask

    // Monitor: outputs are valid every cycle, compared mid-cycle.
    always @(negedge Clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks += 4;
            if (rd_data[0] !== e.d0) begin
                failures++;
                $display("FAIL rd_data0 cyc=%0d addr=%0d got=%h exp=%h", e.cyc, rd_addr[0], rd_data[0], e.d0);
            end
            if (rd_data[1] !== e.d1) begin
                failures++;
                $display("FAIL rd_data1 cyc=%0d addr=%0d got=%h exp=%h", e.cyc, rd_addr[1], rd_data[1], e.d1);
            end
            if (rd_busy !== e.b) begin
                failures++;
                $display("FAIL rd_busy cyc=%0d got=%b exp=%b", e.cyc, rd_busy, e.b);
            end
            if (any_busy !== e.ab) begin
                failures++;
                $display("FAIL any_busy cyc=%0d got=%b exp=%b", e.cyc, any_busy, e.ab);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int r = 0; r < 32; r++) mem[r] = 32'd0;
        busy_m   = '0;
        reset    = 1'b1;
        wr_en    = '0;
        wr_addr  = '0;
        wr_data  = '0;
        iss_en   = 1'b0;
        iss_addr = '0;
        rd_addr  = '0;
        #1;
        step(0);
        step(0);
        idle();

        // All indices read zero and idle after reset.
        for (int i = 0; i < 32; i++) begin
            rd2(5'(i), 5'(31 - i));
            step(1);
        end

        // Same-cycle bypass, then storage.
        wr_en = 2'b01; wr_addr[0] = 5'd5; wr_data[0] = 32'hDEADBEEF;
        rd2(5'd5, 5'd5);
        step(1);
        idle();
        step(1);

        // x0 is never written and never busy.
        wr_en = 2'b01; wr_addr[0] = 5'd0; wr_data[0] = 32'hFFFFFFFF;
        iss_en = 1'b1; iss_addr = 5'd0;
        rd2(5'd0, 5'd0);
        step(1);
        idle();
        repeat (3) step(1);

        // Two ports writing the same register: port 1 wins.
        wr_en = 2'b11;
        wr_addr[0] = 5'd7; wr_data[0] = 32'h11;
        wr_addr[1] = 5'd7; wr_data[1] = 32'h22;
        rd2(5'd7, 5'd7);
        step(1);
        idle();
        step(1);

        // Issue then writeback coinciding with a re-issue.
        iss_en = 1'b1; iss_addr = 5'd3;
        rd2(5'd3, 5'd7);
        step(1);
        idle();
        step(1);
        wr_en = 2'b01; wr_addr[0] = 5'd3; wr_data[0] = 32'h5;
        iss_en = 1'b1; iss_addr = 5'd3;
        step(1);
        idle();
        step(1);
        wr_en = 2'b01; wr_addr[0] = 5'd3; wr_data[0] = 32'h6;
        step(1);
        idle();

        // Busy and data on x9/x10, then reset with a concurrent write.
        wr_en = 2'b11;
        wr_addr[0] = 5'd9;  wr_data[0] = 32'h99;
        wr_addr[1] = 5'd10; wr_data[1] = 32'h1010;
        rd2(5'd9, 5'd10);
        step(1);
        idle();
        iss_en = 1'b1; iss_addr = 5'd9;
        step(1);
        iss_addr = 5'd10;
        step(1);
        idle();
        step(1);
        reset = 1'b1;
        wr_en = 2'b01; wr_addr[0] = 5'd9; wr_data[0] = 32'hBAD;
        step(1);
        idle();
        step(1);
        rd2(5'd3, 5'd7);
        step(1);

        // Randomized traffic with occasional resets and narrow address ranges
        // to provoke conflicts, bypass hits and set/clear collisions.
        for (int c = 0; c < 3000; c++) begin
            bit narrow;
            narrow   = ($urandom_range(0, 1) == 1);
            reset    = ($urandom_range(0, 63) == 0);
            for (int k = 0; k < NW; k++) begin
                wr_en[k]   = ($urandom_range(0, 2) != 0);
                wr_addr[k] = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
                wr_data[k] = $urandom;
            end
            iss_en   = ($urandom_range(0, 2) == 0);
            iss_addr = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            for (int p = 0; p < NR; p++) begin
                if ($urandom_range(0, 2) == 0)
                    rd_addr[p] = wr_addr[$urandom_range(0, NW - 1)];
                else
                    rd_addr[p] = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            end
            step(1);
        end
        idle();

        repeat (3) @(posedge Clk);
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d exp=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
